// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 slice.
// Holds register indices, exception codes, field positions and the PRId value
// that is returned when CP0_PRID_EN is defined.
package cp0_pkg;

   // CP0 register numbers as seen by mfc0/mtc0
   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   // exception codes reported in Cause.ExcCode
   typedef enum logic [4:0] {
      EXC_INT     = 5'd0,
      EXC_ADEL    = 5'd4,
      EXC_ADES    = 5'd5,
      EXC_SYSCALL = 5'd8,
      EXC_RI      = 5'd10,
      EXC_OV      = 5'd12
   } exc_code_e;

   // field bit positions inside SR / Cause
   localparam int IM_HI   = 15;
   localparam int IM_LO   = 10;
   localparam int EXL_BIT = 1;
   localparam int IE_BIT  = 0;
   localparam int BD_BIT  = 31;
   localparam int EXC_HI  = 6;
   localparam int EXC_LO  = 2;

   // processor identification constant
   localparam logic [31:0] PRID_VALUE = 32'h0000_2024;

   // EPC always holds a word address
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_if.sv
// cp0_if: pipeline-side bus of coprocessor-0 (mfc0/mtc0/eret, exception
// inputs, interrupt lines and the request/EPC outputs).
interface cp0_if;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] DOut;
   logic [31:0] EPCOut;
   logic        Req;

   // pipeline side: drives the requests, consumes results
   modport master (
      output A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      input  DOut, EPCOut, Req
   );

   // coprocessor side
   modport slave (
      input  A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      output DOut, EPCOut, Req
   );
endinterface

// File: rtl/cp0.sv
// cp0: coprocessor-0 for the pipelined MIPS core (M stage).
// Holds SR, Cause and EPC, raises Req for interrupts/exceptions, and serves
// mfc0/mtc0/eret. Optional macro CP0_PRID_EN adds a read-only PRId (reg 15).
module cp0
   import cp0_pkg::*;
(
   input  logic clk,
   input  logic reset,
   cp0_if.slave bus
);

   logic [5:0]  im_reg;
   logic        exl_reg;
   logic        ie_reg;
   logic        bd_reg;
   logic [5:0]  ip_reg;
   logic [4:0]  exccode_reg;
   logic [31:0] epc_reg;

   logic        int_req;
   logic        exc_req;
   logic        take_req;
   logic [31:0] epc_next;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   // request logic: EXL blocks both interrupts and exceptions (no nesting)
   assign int_req  = ie_reg & ~exl_reg & (|(bus.HWInt & im_reg));
   assign exc_req  = ~exl_reg & (bus.ExcCodeIn != 5'd0);
   assign take_req = int_req | exc_req;
   assign bus.Req  = take_req & ~reset;

   // a delay-slot instruction restarts at its branch
   assign epc_next   = word_align(bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC);
   assign bus.EPCOut = epc_reg;

   // assemble the software-visible register words, unused bits read 0
   always_comb begin
      sr_word                  = '0;
      sr_word[IM_HI:IM_LO]     = im_reg;
      sr_word[EXL_BIT]         = exl_reg;
      sr_word[IE_BIT]          = ie_reg;
      cause_word               = '0;
      cause_word[BD_BIT]       = bd_reg;
      cause_word[IM_HI:IM_LO]  = ip_reg;
      cause_word[EXC_HI:EXC_LO] = exccode_reg;
   end

   // mfc0 read mux
   always_comb begin
      bus.DOut = '0;
      case (bus.A1)
         REG_SR:    bus.DOut = sr_word;
         REG_CAUSE: bus.DOut = cause_word;
         REG_EPC:   bus.DOut = epc_reg;
`ifdef CP0_PRID_EN
         REG_PRID:  bus.DOut = PRID_VALUE;
`else
         REG_PRID:  bus.DOut = '0;
`endif
         default:   bus.DOut = '0;
      endcase
   end

   // register file update: exception entry wins over mtc0, eret clears EXL last
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_reg      <= '0;
         exl_reg     <= 1'b0;
         ie_reg      <= 1'b0;
         bd_reg      <= 1'b0;
         ip_reg      <= '0;
         exccode_reg <= '0;
         epc_reg     <= '0;
      end else begin
         ip_reg <= bus.HWInt;
         if (take_req) begin
            exl_reg     <= 1'b1;
            bd_reg      <= bus.BDIn;
            exccode_reg <= int_req ? EXC_INT : bus.ExcCodeIn;
            epc_reg     <= epc_next;
         end else begin
            if (bus.WE && (bus.A2 == REG_SR)) begin
               im_reg  <= bus.DIn[IM_HI:IM_LO];
               exl_reg <= bus.DIn[EXL_BIT];
               ie_reg  <= bus.DIn[IE_BIT];
            end
            if (bus.WE && (bus.A2 == REG_EPC)) begin
               epc_reg <= word_align(bus.DIn);
            end
            if (bus.EXLClr) begin
               exl_reg <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed bench for cp0 with a word-level reference model and
// hand-computed literal expectations. Honors CP0_PRID_EN like the design.
`timescale 1ns/100ps
module tb_cp0;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   // reference model state, kept as whole 32-bit register words
   logic [31:0] m_sr;
   logic [31:0] m_cause;
   logic [31:0] m_epc;

   cp0_if bus();

   cp0 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // one comparison
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic m_int();
      return m_sr[0] && !m_sr[1] && ((m_sr[15:10] & bus.HWInt) != 6'd0);
   endfunction

   function automatic logic m_req();
      return !reset && (m_int() || (!m_sr[1] && bus.ExcCodeIn != 5'd0));
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      case (idx)
         5'd12: return m_sr;
         5'd13: return m_cause;
         5'd14: return m_epc;
`ifdef CP0_PRID_EN
         5'd15: return 32'h0000_2024;
`endif
         default: return 32'h0;
      endcase
   endfunction

   // model update from the architectural rules
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_sr    <= 32'h0;
         m_cause <= 32'h0;
         m_epc   <= 32'h0;
      end else if (m_req()) begin
         m_sr    <= m_sr | 32'h2;
         m_cause <= ({31'h0, bus.BDIn} << 31) | ({26'h0, bus.HWInt} << 10)
                    | ({27'h0, (m_int() ? 5'd0 : bus.ExcCodeIn)} << 2);
         m_epc   <= (bus.BDIn ? bus.VPC - 32'd4 : bus.VPC) & ~32'h3;
      end else begin
         m_cause <= (m_cause & ~32'h0000_FC00) | ({26'h0, bus.HWInt} << 10);
         if (bus.WE && bus.A2 == 5'd14) m_epc <= bus.DIn & ~32'h3;
         if (bus.WE && bus.A2 == 5'd12)
            m_sr <= (bus.DIn & 32'h0000_FC03) & (bus.EXLClr ? ~32'h2 : 32'hFFFF_FFFF);
         else if (bus.EXLClr)
            m_sr <= m_sr & ~32'h2;
      end
   end

   // every-cycle compare, just before the rising edge
   always begin
      @(negedge clk);
      #8;
      chk("req_model", {31'h0, bus.Req}, {31'h0, m_req()});
      chk("dout_model", bus.DOut, m_read(bus.A1));
      chk("epcout_model", bus.EPCOut, m_epc);
   end

   // advance to the next drive slot, clearing one-shot inputs
   task automatic cyc(input string tag);
      @(negedge clk);
      #1;
      bus.WE        = 1'b0;
      bus.ExcCodeIn = 5'd0;
      bus.EXLClr    = 1'b0;
      $display("txn t=%0t %s", $time, tag);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      bus.A1 = 5'd12; bus.A2 = 5'd0; bus.DIn = 32'h0; bus.WE = 1'b0;
      bus.VPC = 32'h0; bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0;
      bus.HWInt = 6'd0; bus.EXLClr = 1'b0;

      cyc("reset held");
      cyc("reset held");
      #2;
      chk("reset_sr", bus.DOut, 32'h0);
      chk("reset_req", {31'h0, bus.Req}, 32'h0);

      // mid-run asynchronous reset
      cyc("release, mtc0 SR=FC01");
      reset = 1'b0;
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC01;
      cyc("read SR then async reset");
      bus.A1 = 5'd12;
      #2;
      chk("sr_written", bus.DOut, 32'h0000_FC01);
      #9;
      bus.ExcCodeIn = 5'd8;
      #1;
      reset = 1'b1;
      #1;
      chk("async_req", {31'h0, bus.Req}, 32'h0);
      chk("async_sr", bus.DOut, 32'h0);
      bus.A1 = 5'd13;
      #1;
      chk("async_cause", bus.DOut, 32'h0);
      bus.A1 = 5'd14;
      #1;
      chk("async_epc", bus.DOut, 32'h0);
      cyc("release reset");
      reset = 1'b0;

      // timer interrupt
      cyc("mtc0 SR=0401");
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
      cyc("TC0 irq");
      bus.HWInt = 6'b000001; bus.VPC = 32'h0000_3010; bus.BDIn = 1'b0;
      #2;
      chk("irq_req", {31'h0, bus.Req}, 32'h1);
      cyc("after irq");
      bus.A1 = 5'd13;
      #2;
      chk("irq_cause", bus.DOut, 32'h0000_0400);
      chk("irq_req_blocked", {31'h0, bus.Req}, 32'h0);
      bus.A1 = 5'd14;
      #1;
      chk("irq_epc", bus.DOut, 32'h0000_3010);
      bus.A1 = 5'd12;
      #1;
      chk("irq_sr", bus.DOut, 32'h0000_0403);

      // eret, then delay-slot overflow
      cyc("eret");
      bus.EXLClr = 1'b1; bus.HWInt = 6'd0;
      cyc("Ov in delay slot");
      bus.ExcCodeIn = 5'd12; bus.BDIn = 1'b1; bus.VPC = 32'h0000_3024;
      cyc("after Ov");
      bus.BDIn = 1'b0; bus.A1 = 5'd14;
      #2;
      chk("ds_epc", bus.DOut, 32'h0000_3020);
      bus.A1 = 5'd13;
      #1;
      chk("ds_cause", bus.DOut, 32'h8000_0030);

      // simultaneous interrupt + exception + mtc0
      cyc("eret");
      bus.EXLClr = 1'b1;
      cyc("irq+RI+mtc0");
      bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd10;
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC00;
      #2;
      chk("sim_req", {31'h0, bus.Req}, 32'h1);
      cyc("after simultaneous");
      bus.HWInt = 6'd0; bus.A1 = 5'd13;
      #2;
      chk("sim_cause", bus.DOut, 32'h0000_0400);
      bus.A1 = 5'd12;
      #1;
      chk("sim_sr", bus.DOut, 32'h0000_0403);

      // masking by EXL and IE
      cyc("all lines, EXL=1");
      bus.HWInt = 6'h3F;
      #2;
      chk("exl_mask_req", {31'h0, bus.Req}, 32'h0);
      cyc("IP tracks");
      bus.A1 = 5'd13;
      #2;
      chk("ip_track", bus.DOut, 32'h0000_FC00);
      cyc("mtc0 SR=FC00");
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC00;
      cyc("IE=0");
      #2;
      chk("ie_mask_req", {31'h0, bus.Req}, 32'h0);
      cyc("mtc0 SR=FC03");
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC03;
      cyc("eret with EXL set");
      bus.EXLClr = 1'b1;
      #2;
      chk("exl_still_req", {31'h0, bus.Req}, 32'h0);
      cyc("after eret");
      #2;
      chk("post_eret_req", {31'h0, bus.Req}, 32'h1);
      cyc("eret + mtc0 SR");
      bus.HWInt = 6'd0; bus.A1 = 5'd13;
      bus.EXLClr = 1'b1; bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403;
      #2;
      chk("nest_cause", bus.DOut, 32'h0000_FC00);

      // read-only Cause, EPC write, ignored index
      cyc("mtc0 Cause ignored");
      bus.A1 = 5'd12;
      bus.WE = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
      #2;
      chk("eret_mtc0_sr", bus.DOut, 32'h0000_0401);
      cyc("mtc0 EPC");
      bus.A1 = 5'd13;
      bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h1234_5677;
      #2;
      chk("cause_ro", bus.DOut, 32'h0);
      cyc("mtc0 reg 7");
      bus.A1 = 5'd14;
      bus.WE = 1'b1; bus.A2 = 5'd7; bus.DIn = 32'hFFFF_FFFF;
      #2;
      chk("epc_write", bus.DOut, 32'h1234_5674);
      cyc("mtc0 PRId");
      bus.WE = 1'b1; bus.A2 = 5'd15; bus.DIn = 32'hDEAD_BEEF;
      bus.A1 = 5'd15;
      #2;
`ifdef CP0_PRID_EN
      chk("prid", bus.DOut, 32'h0000_2024);
`else
      chk("prid", bus.DOut, 32'h0);
`endif
      bus.A1 = 5'd7;
      #1;
      chk("read_7", bus.DOut, 32'h0);
      bus.A1 = 5'd12;
      #1;
      chk("sr_after_ignored", bus.DOut, 32'h0000_0401);
      cyc("idle");
      cyc("idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cp0.md
Name: cp0

Overview:
- Coprocessor-0 for the pipelined MIPS CPU; sits in the M stage.
- Consumes the timer-counter IRQ lines on HWInt[5:0] (TC0 on bit 0, TC1 on bit 1, external generator on bit 2) and exception codes from the pipeline.
- Holds SR, Cause and EPC, and raises Req to flush the pipeline and redirect the PC to the handler.
- Serves mfc0/mtc0/eret.

Parameters:
- PRID_VALUE, 32'h0000_2024, constant returned for PRId (reg 15) when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- VPC  in  32  PC of the M-stage instruction.
- BDIn  in  1  M-stage instruction is in a delay slot.
- ExcCodeIn  in  5  M-stage exception code; 0 = none.
- HWInt  in  6  hardware interrupt lines (level).
- EXLClr  in  1  eret in M stage.
- DOut  out  32  mfc0 read data (combinational).
- EPCOut  out  32  current EPC register value.
- Req  out  1  take-exception request (combinational).

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; others read 0.
  - EPC (14): full 32 bits, bits[1:0] forced 0.
- Reset (async, while asserted): SR = Cause = EPC = 0; Req = 0; DOut reflects the zeroed registers; EPCOut = 0.
- IntReq = IE & ~EXL & |(HWInt & IM).
- ExcReq = ~EXL & (ExcCodeIn != 0).
- Req = (IntReq | ExcReq) & ~reset, same cycle, no latency.
- Cause.IP <= HWInt every cycle, unconditionally, including while EXL = 1.
- On a clock edge with Req = 1:
  - EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn. Interrupt has priority over a simultaneous exception.
  - EPC <= BDIn ? VPC-4 : VPC, with bits[1:0] cleared.
  - Any mtc0 in the same cycle is suppressed.
- mtc0 (WE = 1, Req = 0):
  - A2 = 12 writes SR (IM, EXL, IE only).
  - A2 = 14 writes EPC (DIn with bits[1:0] = 0).
  - A2 = 13 writes nothing; Cause is read-only to software.
  - Any other A2 value is ignored.
  - The write takes effect at the edge; the new value is visible on DOut/Req the next cycle, with no internal bypass.
- EXLClr = 1: EXL <= 0 at the edge.
  - EXLClr and Req cannot coincide, because EXL = 1 blocks Req.
  - EXLClr with mtc0 to SR in the same cycle: EXL ends 0; IM/IE take DIn.
- DOut:
  - A1 = 12/13/14 returns the masked register.
  - A1 = 15 follows the feature below.
  - Any other A1 returns 0.
- Nesting: while EXL = 1, neither interrupts nor exceptions are taken; IP keeps tracking.

Optional Feature:
- Macro CP0_PRID_EN.
- Defined: A1 = 15 returns PRID_VALUE; mtc0 to 15 is ignored.
- Undefined: A1 = 15 returns 0; no PRId logic is generated.

Decomposition:
- Shared package cp0_pkg holds:
  - Register indices: SR = 12, CAUSE = 13, EPC = 14, PRID = 15.
  - ExcCode constants: INT = 0, ADEL = 4, ADES = 5, SYSCALL = 8, RI = 10, OV = 12.
  - Field bit positions: IM/IP 15:10, EXL 1, IE 0, BD 31, ExcCode 6:2.
- No sub-module: the logic is one register file plus request logic.

Test Plan:
- Reset mid-run: set SR = 32'h0000_FC01, assert reset asynchronously between edges -> SR/Cause/EPC read 0 immediately, Req = 0.
- Timer interrupt: mtc0 SR = 32'h0000_0401 (IM[10] = 1, IE = 1), HWInt = 6'b000001, VPC = 32'h0000_3010, BDIn = 0 -> Req = 1 same cycle; next cycle Cause.ExcCode = 0, IP[10] = 1, EPC = 32'h0000_3010, EXL = 1, Req = 0.
- Delay-slot exception: ExcCodeIn = 12 (Ov), BDIn = 1, VPC = 32'h0000_3024 -> EPC = 32'h0000_3020, Cause = 32'h8000_0030.
- Simultaneous: HWInt[0] enabled + ExcCodeIn = 10 -> ExcCode = 0; mtc0 SR in the same cycle is discarded.
- Masking/EXL: IE = 0 or EXL = 1 with HWInt = 6'h3F -> Req = 0, Cause.IP = 6'h3F; then EXLClr -> EXL = 0 and Req rises next cycle if IE & IM are set.
- PRId: mfc0 A1 = 15 -> 32'h0000_2024 with CP0_PRID_EN, 0 without; A1 = 7 -> 0.
